multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL provide parameter CLK_FREQ_HZ, default 27000000, input clock frequency.
REQ-002 SHALL provide parameter TICK_HZ, default 1000, countdown unit rate; TICKS = CLK_FREQ_HZ/TICK_HZ, which must be >= 1.
REQ-003 SHALL provide parameter NUM_CH, default 4, number of independent channels (1..16).
REQ-004 SHALL provide parameter CNT_W, default 16, countdown width in units.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  NUM_CH  per-channel load-and-run pulse.
REQ-008 SHALL have port stop  input  NUM_CH  per-channel abort pulse.
REQ-009 SHALL have port load_val  input  NUM_CH*CNT_W  per-channel count; channel i is bits [i*CNT_W +: CNT_W].
REQ-010 SHALL have port periodic  input  NUM_CH  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot.
REQ-011 SHALL have port irq_en  input  NUM_CH  per-channel interrupt enable.
REQ-012 SHALL have port irq_clr  input  NUM_CH  per-channel pending-flag clear pulse.
REQ-013 SHALL have port done  output  NUM_CH  1 when the channel is IDLE.
REQ-014 SHALL have port evt  output  NUM_CH  1-cycle pulse on expiry.
REQ-015 SHALL have port remaining  output  NUM_CH*CNT_W  current unit count per channel.
REQ-016 SHALL have port irq_pending  output  NUM_CH  sticky expiry flags.
REQ-017 SHALL have port irq  output  1  OR of irq_pending.

Function
REQ-018 Each channel SHALL be an independent two-state FSM (IDLE, RUN) with its own prescaler (width clog2(TICKS), min 1), unit counter (CNT_W) and latched reload value and mode.
REQ-019 IDLE with start=1, stop=0 and load_val!=0 SHALL go to RUN: counter<=load_val, reload<=load_val, mode<=periodic, prescaler<=0.
REQ-020 IDLE with start and load_val=0 SHALL be ignored: no state change, no evt.
REQ-021 In RUN, the prescaler SHALL count 0..TICKS-1; at TICKS-1 it wraps to 0 and the counter decrements by 1.
REQ-022 Expiry SHALL occur on the decrement edge where the counter goes 1->0: exactly N*TICKS clock edges after the start edge for load N.
REQ-023 On expiry, evt SHALL pulse high for exactly the one cycle following the expiry edge.
REQ-024 On one-shot expiry the channel SHALL go IDLE with counter=0 and done=1 from the expiry edge.
REQ-025 On periodic expiry the channel SHALL stay in RUN with counter<=reload and prescaler<=0, giving period reload*TICKS with no gap cycle; done stays 0.
REQ-026 start in RUN SHALL restart the channel with the new load_val/periodic and prescaler<=0; a start with load_val=0 in RUN behaves as stop.
REQ-027 A start coinciding with expiry SHALL win: restart taken, evt suppressed.
REQ-028 stop in RUN SHALL go IDLE, counter<=0, done=1, with no evt and no pending set.
REQ-029 When start and stop are asserted together, stop SHALL win.
REQ-030 done SHALL be 0 in RUN and 1 in IDLE, registered.
REQ-031 irq_pending[i] SHALL set on expiry when irq_en[i]=1 and clear on irq_clr[i].
REQ-032 When expiry and irq_clr coincide, set SHALL win.
REQ-033 irq_en=0 at expiry SHALL leave pending unchanged; later changes of irq_en do not affect an already-set pending flag.
REQ-034 irq SHALL be combinational OR of irq_pending.
REQ-035 remaining SHALL show the registered unit counter.
REQ-036 Channels SHALL NOT interact; simultaneous events on all channels SHALL all be honoured.

Reset
REQ-037 rst_n=0 SHALL asynchronously force all channels IDLE: done all 1, evt 0, remaining 0, irq_pending 0, irq 0, prescalers/reload/mode 0.
REQ-038 Reset mid-count SHALL abort without evt or pending; operation resumes on the first edge after rst_n deasserts.

Verification (CLK_FREQ_HZ=1000, TICK_HZ=100 -> TICKS=10, NUM_CH=4, CNT_W=8)
REQ-039 One-shot: ch0 start, load 3, irq_en=1 -> done=0 next edge; evt pulse, done=1, irq_pending[0]=1 at edge 30; irq_clr -> irq=0.
REQ-040 Periodic: ch1 load 2, periodic=1 -> evt at edges 20, 40, 60; stop at edge 45 -> done=1, no evt at 60.
REQ-041 Restart and ignore: ch2 load 5, restart at edge 12 with load 1 -> evt at edge 22 only; start with load 0 while IDLE -> done stays 1.
REQ-042 Collisions: start+stop together -> stays IDLE; irq_clr on an expiry edge -> pending=1; start on an expiry edge -> no evt.
REQ-043 Concurrency and reset: all four channels load 4 simultaneously -> four evt at edge 40; rst_n low at edge 25 on a fresh run -> all outputs at reset values immediately, no evt.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent countdown timers sharing one clock.
// Each channel counts load_val units of TICKS clocks, then either stops
// (one-shot) or reloads (periodic), pulsing evt and optionally latching an
// interrupt pending flag.
//
// Ports
//   clk, rst_n   : clock (rising edge), async active-low reset
//   start        : [NUM_CH] load-and-run pulse (load_val == 0 acts as stop)
//   stop         : [NUM_CH] abort pulse, beats start
//   load_val     : [NUM_CH*CNT_W] unit count, channel i at [i*CNT_W +: CNT_W]
//   periodic     : [NUM_CH] mode captured at start, 1 = auto-reload
//   irq_en       : [NUM_CH] expiry sets irq_pending when high
//   irq_clr      : [NUM_CH] clears irq_pending (loses to a same-cycle set)
//   done         : [NUM_CH] channel idle
//   evt          : [NUM_CH] one-cycle expiry pulse
//   remaining    : [NUM_CH*CNT_W] current unit count
//   irq_pending  : [NUM_CH] sticky expiry flags
//   irq          : OR of irq_pending
`timescale 1ns/1ps
module multi_timer #(
   parameter int CLK_FREQ_HZ = 27000000,
   parameter int TICK_HZ     = 1000,
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH*CNT_W-1:0] load_val,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH-1:0]       irq_en,
   input  logic [NUM_CH-1:0]       irq_clr,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       evt,
   output logic [NUM_CH*CNT_W-1:0] remaining,
   output logic [NUM_CH-1:0]       irq_pending,
   output logic                    irq
);
   localparam int TICKS = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(TICKS - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_t             state_q, state_d;
      logic [PW-1:0]      presc_q, presc_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d;
      logic [CNT_W-1:0]   reload_q, reload_d;
      logic               mode_q, mode_d;
      logic               evt_q, evt_d;
      logic               pend_q, pend_d;
      logic               expire;
      logic [CNT_W-1:0]   lv;

      assign lv = load_val[i*CNT_W +: CNT_W];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            evt_q    <= 1'b0;
            pend_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            evt_q    <= evt_d;
            pend_q   <= pend_d;
         end
      end

      // Priority: stop > start > counting. Because start is checked before
      // the counting branch, a start landing on the expiry edge restarts the
      // channel and the expiry (evt and pending set) never happens.
      always_comb begin
         state_d  = state_q;
         presc_d  = presc_q;
         cnt_d    = cnt_q;
         reload_d = reload_q;
         mode_d   = mode_q;
         expire   = 1'b0;
         if (stop[i]) begin
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = '0;
         end else if (start[i] && lv != '0) begin
            state_d  = RUN;
            cnt_d    = lv;
            reload_d = lv;
            mode_d   = periodic[i];
            presc_d  = '0;
         end else if (start[i] && state_q == RUN) begin
            // zero-length restart degenerates to an abort
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = '0;
         end else if (state_q == RUN) begin
            if (presc_q == PS_LAST) begin
               presc_d = '0;
               if (cnt_q == CNT_W'(1)) begin
                  expire = 1'b1;
                  if (mode_q) begin
                     cnt_d = reload_q;    // back-to-back period, no gap cycle
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         evt_d = expire;
         // set beats clear when both land on the same edge
         if (expire && irq_en[i])
            pend_d = 1'b1;
         else if (irq_clr[i])
            pend_d = 1'b0;
         else
            pend_d = pend_q;
      end

      assign done[i]                     = (state_q == IDLE);
      assign evt[i]                      = evt_q;
      assign remaining[i*CNT_W +: CNT_W] = cnt_q;
      assign irq_pending[i]              = pend_q;
   end

   assign irq = |irq_pending;

endmodule

// File: tb/tb_multi_timer.sv
`timescale 1ns/1ps
module tb_multi_timer;
   localparam int CLK_FREQ_HZ = 1000;
   localparam int TICK_HZ     = 100;
   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 8;
   localparam int TICKS       = CLK_FREQ_HZ / TICK_HZ;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [NUM_CH-1:0]       start = '0, stop = '0, periodic = '0;
   logic [NUM_CH-1:0]       irq_en = '0, irq_clr = '0;
   logic [NUM_CH*CNT_W-1:0] load_val = '0;
   logic [NUM_CH-1:0]       done, evt, irq_pending;
   logic [NUM_CH*CNT_W-1:0] remaining;
   logic                    irq;

   int vecs = 0;
   int errs = 0;

   multi_timer #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .TICK_HZ(TICK_HZ),
                 .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .load_val(load_val), .periodic(periodic), .irq_en(irq_en),
      .irq_clr(irq_clr), .done(done), .evt(evt), .remaining(remaining),
      .irq_pending(irq_pending), .irq(irq));

   always #5 clk = ~clk;

   // Reference model: a channel is "running with load n, e edges since load".
   // Expiry happens when e reaches n*TICKS; the displayed count is derived
   // arithmetically as n - e/TICKS.
   typedef struct {
      bit run; bit per; int n; int e; bit ex; bit pend;
   } mch_t;

   mch_t m [NUM_CH];

   function automatic mch_t nxt(mch_t c, bit st, bit sp, bit pr, int lv,
                                bit en, bit clr);
      mch_t r;
      r = c;
      r.ex = 1'b0;
      if (sp) r.run = 1'b0;
      else if (st) begin
         if (lv != 0) begin r.run = 1'b1; r.n = lv; r.per = pr; r.e = 0; end
         else r.run = 1'b0;
      end else if (c.run) begin
         r.e = c.e + 1;
         if (r.e == c.n * TICKS) begin
            r.ex = 1'b1;
            if (c.per) r.e = 0; else r.run = 1'b0;
         end
      end
      if (r.ex && en) r.pend = 1'b1;
      else if (clr) r.pend = 1'b0;
      return r;
   endfunction

   function automatic int exp_rem(mch_t c);
      return c.run ? c.n - c.e / TICKS : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) m[i] <= '{default: 0};
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            m[i] <= nxt(m[i], start[i], stop[i], periodic[i],
                        int'(load_val[i*CNT_W +: CNT_W]), irq_en[i], irq_clr[i]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input int ch, input int v);
      load_val[ch*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      vecs++; if (done !== 4'hF) begin errs++; $display("FAIL reset_done got %h want f", done); end
      vecs++; if (evt !== 4'h0) begin errs++; $display("FAIL reset_evt got %h want 0", evt); end
      vecs++; if (remaining !== '0) begin errs++; $display("FAIL reset_remaining got %h want 0", remaining); end
      vecs++; if (irq_pending !== 4'h0 || irq !== 1'b0) begin errs++; $display("FAIL reset_irq got %h/%b want 0/0", irq_pending, irq); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_oneshot();
      int bad = 0;
      irq_en = 4'b0001; set_load(0, 3); start = 4'b0001;
      step(); start = '0;
      vecs++; if (done[0] !== 1'b0) begin errs++; $display("FAIL oneshot_run got done=%b want 0", done[0]); end
      for (int k = 1; k < 30; k++) begin
         step();
         if (evt[0] !== 1'b0 || done[0] !== 1'b0) bad++;
         if (k == 15 && remaining[7:0] !== 8'd2) bad++;
      end
      vecs++; if (bad != 0) begin errs++; $display("FAIL oneshot_early got %0d bad cycles want 0", bad); end
      step();
      vecs++; if (evt[0] !== 1'b1 || done[0] !== 1'b1) begin errs++; $display("FAIL oneshot_expiry got evt=%b done=%b want 1/1", evt[0], done[0]); end
      vecs++; if (irq_pending[0] !== 1'b1 || irq !== 1'b1) begin errs++; $display("FAIL oneshot_pend got %b/%b want 1/1", irq_pending[0], irq); end
      step();
      vecs++; if (evt[0] !== 1'b0) begin errs++; $display("FAIL oneshot_evt_width got %b want 0", evt[0]); end
      irq_clr = 4'b0001; step(); irq_clr = '0;
      vecs++; if (irq !== 1'b0) begin errs++; $display("FAIL oneshot_clr got irq=%b want 0", irq); end
      irq_en = '0;
   endtask

   task automatic test_periodic();
      int bad = 0;
      set_load(1, 2); periodic = 4'b0010; start = 4'b0010;
      step(); start = '0; periodic = '0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 45) stop = 4'b0010;
         step();
         stop = '0;
         if (evt[1] !== (k == 20 || k == 40)) bad++;
         if (k == 25 && remaining[15:8] !== 8'd2) bad++;
         if (k == 30 && remaining[15:8] !== 8'd1) bad++;
      end
      vecs++; if (bad != 0) begin errs++; $display("FAIL periodic_events got %0d bad cycles want 0", bad); end
      vecs++; if (done[1] !== 1'b1 || remaining[15:8] !== 8'd0) begin errs++; $display("FAIL periodic_stop got done=%b rem=%0d want 1/0", done[1], remaining[15:8]); end
   endtask

   task automatic test_restart();
      int bad = 0;
      set_load(2, 5); start = 4'b0100;
      step(); start = '0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 12) begin set_load(2, 1); start = 4'b0100; end
         step();
         start = '0;
         if (evt[2] !== (k == 22)) bad++;
      end
      vecs++; if (bad != 0) begin errs++; $display("FAIL restart_events got %0d bad cycles want 0", bad); end
      set_load(2, 0); start = 4'b0100;
      step(); start = '0;
      vecs++; if (done[2] !== 1'b1 || evt[2] !== 1'b0) begin errs++; $display("FAIL ignore_zero got done=%b evt=%b want 1/0", done[2], evt[2]); end
   endtask

   task automatic test_collisions();
      set_load(3, 4); start = 4'b1000; stop = 4'b1000;
      step(); start = '0; stop = '0;
      vecs++; if (done[3] !== 1'b1 || remaining[31:24] !== 8'd0) begin errs++; $display("FAIL start_stop got done=%b rem=%0d want 1/0", done[3], remaining[31:24]); end
      // clear on the expiry edge loses to the set
      irq_en = 4'b0001; set_load(0, 1); start = 4'b0001;
      step(); start = '0;
      repeat (9) step();
      irq_clr = 4'b0001; step(); irq_clr = '0;
      vecs++; if (evt[0] !== 1'b1 || irq_pending[0] !== 1'b1) begin errs++; $display("FAIL clr_vs_set got evt=%b pend=%b want 1/1", evt[0], irq_pending[0]); end
      irq_clr = 4'b0001; step(); irq_clr = '0;
      // start on the expiry edge wins, no event
      set_load(0, 1); start = 4'b0001;
      step(); start = '0;
      repeat (9) step();
      set_load(0, 2); start = 4'b0001; step(); start = '0;
      vecs++; if (evt[0] !== 1'b0 || done[0] !== 1'b0 || remaining[7:0] !== 8'd2 || irq_pending[0] !== 1'b0) begin
         errs++; $display("FAIL start_on_expiry got evt=%b done=%b rem=%0d pend=%b want 0/0/2/0", evt[0], done[0], remaining[7:0], irq_pending[0]);
      end
      stop = 4'b0001; step(); stop = '0;
      irq_en = '0;
   endtask

   task automatic test_concurrency_reset();
      int bad = 0;
      irq_en = 4'hF;
      for (int i = 0; i < NUM_CH; i++) set_load(i, 4);
      start = 4'hF; step(); start = '0;
      repeat (39) begin step(); if (evt !== 4'h0) bad++; end
      step();
      vecs++; if (bad != 0 || evt !== 4'hF || done !== 4'hF) begin errs++; $display("FAIL all_expire got evt=%h done=%h early=%0d want f/f/0", evt, done, bad); end
      start = 4'hF; step(); start = '0;
      repeat (25) step();
      rst_n = 1'b0;
      #1;
      vecs++; if (done !== 4'hF || evt !== 4'h0 || remaining !== '0 || irq_pending !== 4'h0 || irq !== 1'b0) begin
         errs++; $display("FAIL async_reset got done=%h evt=%h rem=%h pend=%h irq=%b", done, evt, remaining, irq_pending, irq);
      end
      repeat (3) step();
      rst_n = 1'b1;
      bad = 0;
      repeat (30) begin step(); if (evt !== 4'h0 || done !== 4'hF) bad++; end
      vecs++; if (bad != 0) begin errs++; $display("FAIL post_reset_quiet got %0d bad cycles want 0", bad); end
      set_load(0, 1); start = 4'b0001; step(); start = '0;
      vecs++; if (done[0] !== 1'b0) begin errs++; $display("FAIL resume got done=%b want 0", done[0]); end
      stop = 4'hF; step(); stop = '0;
      irq_clr = 4'hF; step(); irq_clr = '0;
      irq_en = '0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            start[i]    = ($urandom_range(0, 39) == 0);
            stop[i]     = ($urandom_range(0, 149) == 0);
            irq_clr[i]  = ($urandom_range(0, 15) == 0);
            irq_en[i]   = $urandom_range(0, 1);
            periodic[i] = $urandom_range(0, 1);
            set_load(i, $urandom_range(0, 4));
         end
         step();
         for (int i = 0; i < NUM_CH; i++) begin
            vecs++; if (done[i] !== !m[i].run) begin errs++; $display("FAIL rnd_done ch%0d cyc%0d got %b want %b", i, n, done[i], !m[i].run); end
            vecs++; if (evt[i] !== m[i].ex) begin errs++; $display("FAIL rnd_evt ch%0d cyc%0d got %b want %b", i, n, evt[i], m[i].ex); end
            vecs++; if (remaining[i*CNT_W +: CNT_W] !== CNT_W'(exp_rem(m[i]))) begin
               errs++; $display("FAIL rnd_remaining ch%0d cyc%0d got %0d want %0d", i, n, remaining[i*CNT_W +: CNT_W], exp_rem(m[i]));
            end
            vecs++; if (irq_pending[i] !== m[i].pend) begin errs++; $display("FAIL rnd_pend ch%0d cyc%0d got %b want %b", i, n, irq_pending[i], m[i].pend); end
         end
         vecs++; if (irq !== (m[0].pend | m[1].pend | m[2].pend | m[3].pend)) begin errs++; $display("FAIL rnd_irq cyc%0d got %b", n, irq); end
      end
      start = '0; stop = '0; irq_clr = '0; irq_en = '0; periodic = '0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_restart();
      test_collisions();
      test_concurrency_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
